// File: rtl/l2cache_pkg.sv
// Shared types and width helpers for the L2 cache control slice.
package l2cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_OPER,
    S_CHK_DIRTY,
    S_WB,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_REFILL_WRITE
  } state_t;

  function automatic int calc_way_w(input int w);
    return $clog2(w);
  endfunction

  function automatic int calc_src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2cache_rr_arbiter.sv
// Round-robin arbiter; pointer holds the last granted source.
module l2cache_rr_arbiter
  import l2cache_pkg::*;
#(
  parameter int n_src = 2,
  localparam int src_w = calc_src_w(n_src)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [n_src-1:0] req,
  input  logic             en,
  output logic [n_src-1:0] gnt,
  output logic [src_w-1:0] idx
);

  logic [src_w-1:0] last;
  logic             found;

  // Search sources above the pointer first, then wrap to the bottom.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int j = 0; j < n_src; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        found = 1'b1;
        idx   = src_w'(j);
      end
    end
    for (int j = 0; j < n_src; j++) begin
      if (!found && req[j] && (j <= int'(last))) begin
        found = 1'b1;
        idx   = src_w'(j);
      end
    end
    for (int j = 0; j < n_src; j++) begin
      gnt[j] = found && (int'(idx) == j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last <= src_w'(n_src - 1);
    end else if (en && found) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/l2cache_ctrl_fsm.sv
// Main L2 control FSM: arbitration, lookup, writeback, refill, cache-op.
module l2cache_ctrl_fsm
  import l2cache_pkg::*;
#(
  parameter int way = 4,
  parameter int n_src = 2,
  localparam int way_w = calc_way_w(way),
  localparam int src_w = calc_src_w(n_src)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [n_src-1:0] req,
  input  logic [n_src-1:0] req_we,
  input  logic             opflag,
  output logic [n_src-1:0] addr_ok,
  output logic [n_src-1:0] data_ok,
  output logic             op_done,
  output logic             rbuf_we,
  output logic [src_w-1:0] cur_src,
  input  logic [way-1:0]   hit,
  input  logic [way_w-1:0] victim,
  input  logic             victim_dirty,
  output logic [way-1:0]   use_way,
  output logic [way-1:0]   data_we,
  output logic             data_replace,
  output logic [way_w-1:0] tagv_way_sel,
  output logic [way_w-1:0] dirty_way_sel,
  output logic [way_w-1:0] choose_way,
  output logic             dirty_set1,
  output logic             dirty_set0,
  output logic             choose_return,
  output logic             mem_req_r,
  output logic             mem_req_w,
  output logic             mem_rdy,
  input  logic             mem_addrok_r,
  input  logic             mem_addrok_w,
  input  logic             mem_dataok,
  output logic             busy
);

  state_t           state, nxt;
  logic             cur_we;
  logic [way_w-1:0] vw;
  logic [way_w-1:0] hidx;
  logic             hit_any;
  logic             arb_en;
  logic [n_src-1:0] gnt;
  logic [src_w-1:0] gidx;
  logic [n_src-1:0] src_oh;
  logic [way-1:0]   hit_oh;
  logic [way-1:0]   vw_oh;

  assign arb_en = (state == S_IDLE) && !opflag;

  l2cache_rr_arbiter #(.n_src(n_src)) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (gidx)
  );

  // Lowest set hit bit wins.
  always_comb begin
    hidx = '0;
    for (int i = way - 1; i >= 0; i--) begin
      if (hit[i]) hidx = way_w'(i);
    end
  end

  assign hit_any = |hit;
  assign hit_oh  = way'(1) << hidx;
  assign vw_oh   = way'(1) << vw;
  assign src_oh  = n_src'(1) << cur_src;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cur_src <= '0;
      cur_we  <= 1'b0;
      vw      <= '0;
    end else begin
      state <= nxt;
      if (rbuf_we) begin
        cur_src <= gidx;
        cur_we  <= req_we[gidx];
      end
      if (state == S_LOOKUP && !hit_any) vw <= victim;
    end
  end

  always_comb begin
    nxt           = state;
    addr_ok       = '0;
    data_ok       = '0;
    op_done       = 1'b0;
    rbuf_we       = 1'b0;
    use_way       = '0;
    data_we       = '0;
    data_replace  = 1'b0;
    tagv_way_sel  = '0;
    dirty_way_sel = '0;
    choose_way    = '0;
    dirty_set1    = 1'b0;
    dirty_set0    = 1'b0;
    choose_return = 1'b0;
    mem_req_r     = 1'b0;
    mem_req_w     = 1'b0;
    mem_rdy       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (opflag) begin
          nxt = S_OPER;
        end else if (|req) begin
          addr_ok = gnt;
          rbuf_we = 1'b1;
          nxt     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          use_way    = hit_oh;
          choose_way = hidx;
          data_ok    = src_oh;
          if (cur_we) begin
            data_we       = hit_oh;
            dirty_way_sel = hidx;
            dirty_set1    = 1'b1;
          end
          nxt = S_IDLE;
        end else begin
          nxt = S_CHK_DIRTY;
        end
      end
      S_CHK_DIRTY: begin
        dirty_way_sel = vw;
        nxt = victim_dirty ? S_WB : S_REFILL_REQ;
      end
      S_WB: begin
        mem_req_w    = 1'b1;
        choose_way   = vw;
        tagv_way_sel = vw;
        if (mem_addrok_w) nxt = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        mem_req_r = 1'b1;
        if (mem_addrok_r) nxt = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        mem_rdy = 1'b1;
        if (mem_dataok) begin
          choose_return = 1'b1;
          data_replace  = 1'b1;
          data_we       = vw_oh;
          dirty_way_sel = vw;
          dirty_set0    = 1'b1;
          if (cur_we) begin
            nxt = S_REFILL_WRITE;
          end else begin
            use_way = vw_oh;
            data_ok = src_oh;
            nxt     = S_IDLE;
          end
        end
      end
      // Merge the pending store into the freshly refilled block.
      S_REFILL_WRITE: begin
        data_we       = vw_oh;
        use_way       = vw_oh;
        dirty_way_sel = vw;
        dirty_set1    = 1'b1;
        data_ok       = src_oh;
        nxt           = S_IDLE;
      end
      S_OPER: begin
        op_done = 1'b1;
        nxt     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2cache_ctrl_fsm.sv
// Randomized and directed bench for l2cache_ctrl_fsm against a timeline model.
module tb_l2cache_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [1:0] req, req_we, addr_ok, data_ok;
  logic       opflag, op_done, rbuf_we;
  logic [0:0] cur_src;
  logic [3:0] hit, use_way, data_we;
  logic [1:0] victim, tagv_way_sel, dirty_way_sel, choose_way;
  logic       victim_dirty, data_replace, dirty_set1, dirty_set0;
  logic       choose_return, mem_req_r, mem_req_w, mem_rdy;
  logic       mem_addrok_r, mem_addrok_w, mem_dataok, busy;

  l2cache_ctrl_fsm #(.way(4), .n_src(2)) u (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we),
    .opflag(opflag), .addr_ok(addr_ok), .data_ok(data_ok),
    .op_done(op_done), .rbuf_we(rbuf_we), .cur_src(cur_src),
    .hit(hit), .victim(victim), .victim_dirty(victim_dirty),
    .use_way(use_way), .data_we(data_we), .data_replace(data_replace),
    .tagv_way_sel(tagv_way_sel), .dirty_way_sel(dirty_way_sel),
    .choose_way(choose_way), .dirty_set1(dirty_set1),
    .dirty_set0(dirty_set0), .choose_return(choose_return),
    .mem_req_r(mem_req_r), .mem_req_w(mem_req_w), .mem_rdy(mem_rdy),
    .mem_addrok_r(mem_addrok_r), .mem_addrok_w(mem_addrok_w),
    .mem_dataok(mem_dataok), .busy(busy)
  );

  logic [2:0] req8, req_we8, addr_ok8, data_ok8;
  logic       op_done8, rbuf_we8;
  logic [1:0] cur_src8;
  logic [7:0] hit8, use8, data_we8;
  logic [2:0] victim8, tagv8, dsel8, choose8;
  logic       drep8, ds1_8, ds0_8, cret8, mrr8, mrw8, mrdy8, busy8;
  logic       zero8;

  l2cache_ctrl_fsm #(.way(8), .n_src(3)) u8 (
    .clk(clk), .rstn(rstn), .req(req8), .req_we(req_we8),
    .opflag(zero8), .addr_ok(addr_ok8), .data_ok(data_ok8),
    .op_done(op_done8), .rbuf_we(rbuf_we8), .cur_src(cur_src8),
    .hit(hit8), .victim(victim8), .victim_dirty(zero8),
    .use_way(use8), .data_we(data_we8), .data_replace(drep8),
    .tagv_way_sel(tagv8), .dirty_way_sel(dsel8),
    .choose_way(choose8), .dirty_set1(ds1_8),
    .dirty_set0(ds0_8), .choose_return(cret8),
    .mem_req_r(mrr8), .mem_req_w(mrw8), .mem_rdy(mrdy8),
    .mem_addrok_r(zero8), .mem_addrok_w(zero8),
    .mem_dataok(zero8), .busy(busy8)
  );

  int n_checks = 0;
  int n_pass = 0;
  int m_last;

  // Round-robin reference: first requester after the last grant.
  function automatic int rr(input int last, input logic [1:0] r);
    for (int i = 1; i <= 2; i++) begin
      if (r[(last + i) % 2]) return (last + i) % 2;
    end
    return -1;
  endfunction

  function automatic int lowest(input logic [3:0] h);
    for (int i = 0; i < 4; i++) if (h[i]) return i;
    return -1;
  endfunction

  function automatic logic [1:0] oh2(input int g);
    return (g < 0) ? 2'b00 : 2'(1 << g);
  endfunction

  function automatic logic [3:0] oh4(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req = '0; req_we = '0; opflag = 0; hit = '0; victim = '0;
    victim_dirty = 0; mem_addrok_r = 0; mem_addrok_w = 0;
    mem_dataok = 0; req8 = '0; req_we8 = '0; hit8 = '0;
    victim8 = '0; zero8 = 0;
  endtask

  task automatic test_reset();
    quiet();
    rstn = 0;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (cur_src !== 1'b0) $display("FAIL reset_cur_src got=%b exp=0", cur_src); else n_pass++;
    n_checks++;
    if ({addr_ok, data_ok, use_way, data_we, mem_req_r, mem_req_w, mem_rdy, op_done, rbuf_we} !== '0)
      $display("FAIL reset_outputs got=%b exp=0",
        {addr_ok, data_ok, use_way, data_we, mem_req_r, mem_req_w, mem_rdy, op_done, rbuf_we});
    else n_pass++;
    tick();
    rstn = 1;
    m_last = 1;
  endtask

  task automatic test_alternate();
    int g;
    req = 2'b11; req_we = 2'b00; hit = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      g = rr(m_last, req);
      m_last = g;
      @(negedge clk);
      n_checks++; if (addr_ok !== oh2(g)) $display("FAIL alt_addr_ok t=%0d got=%b exp=%b", t, addr_ok, oh2(g)); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if (data_ok !== oh2(g)) $display("FAIL alt_data_ok t=%0d got=%b exp=%b", t, data_ok, oh2(g)); else n_pass++;
      n_checks++; if (addr_ok !== 2'b00) $display("FAIL alt_no_accept t=%0d got=%b exp=00", t, addr_ok); else n_pass++;
      tick();
    end
    quiet();
  endtask

  task automatic test_way8();
    req8 = 3'b100;
    @(negedge clk);
    n_checks++; if (addr_ok8 !== 3'b100) $display("FAIL w8_addr_ok got=%b exp=100", addr_ok8); else n_pass++;
    tick();
    req8 = 3'b000; hit8 = 8'b0010_0000;
    @(negedge clk);
    n_checks++; if (use8 !== 8'b0010_0000) $display("FAIL w8_use got=%b exp=00100000", use8); else n_pass++;
    n_checks++; if (choose8 !== 3'd5) $display("FAIL w8_choose_way got=%0d exp=5", choose8); else n_pass++;
    n_checks++; if (data_ok8 !== 3'b100) $display("FAIL w8_data_ok got=%b exp=100", data_ok8); else n_pass++;
    n_checks++; if (cur_src8 !== 2'd2) $display("FAIL w8_cur_src got=%0d exp=2", cur_src8); else n_pass++;
    tick();
    req8 = 3'b111;
    @(negedge clk);
    n_checks++; if (addr_ok8 !== 3'b001) $display("FAIL w8_wrap got=%b exp=001", addr_ok8); else n_pass++;
    tick();
    req8 = 3'b000;
    @(negedge clk);
    n_checks++; if (data_ok8 !== 3'b001) $display("FAIL w8_data_ok2 got=%b exp=001", data_ok8); else n_pass++;
    tick();
    quiet();
  endtask

  task automatic test_write_miss();
    int g;
    req = 2'b10; req_we = 2'b11;
    g = rr(m_last, req);
    m_last = g;
    for (int c = 0; c <= 9; c++) begin
      hit = 4'b0000;
      victim = (c == 1) ? 2'd2 : 2'($urandom_range(0, 3));
      victim_dirty = 0;
      mem_addrok_r = (c == 5);
      mem_dataok = (c == 8);
      if (c > 0) req = 2'b00;
      @(negedge clk);
      if (c == 7) begin
        n_checks++; if (mem_rdy !== 1'b1 || data_we !== 4'b0) $display("FAIL wm_wait got=%b/%b exp=1/0000", mem_rdy, data_we); else n_pass++;
      end
      if (c == 8) begin
        n_checks++;
        if ({data_replace, dirty_set0, choose_return, dirty_set1} !== 4'b1110)
          $display("FAIL wm_refill_flags got=%b exp=1110", {data_replace, dirty_set0, choose_return, dirty_set1});
        else n_pass++;
        n_checks++; if (data_we !== 4'b0100) $display("FAIL wm_refill_we got=%b exp=0100", data_we); else n_pass++;
        n_checks++; if (dirty_way_sel !== 2'd2) $display("FAIL wm_dsel got=%0d exp=2", dirty_way_sel); else n_pass++;
        n_checks++; if (data_ok !== 2'b00) $display("FAIL wm_early_data_ok got=%b exp=00", data_ok); else n_pass++;
      end
      if (c == 9) begin
        n_checks++; if (dirty_set1 !== 1'b1 || dirty_set0 !== 1'b0) $display("FAIL wm_write_dirty got=%b%b exp=10", dirty_set1, dirty_set0); else n_pass++;
        n_checks++; if (data_ok !== oh2(g)) $display("FAIL wm_data_ok got=%b exp=%b", data_ok, oh2(g)); else n_pass++;
        n_checks++; if (data_we !== 4'b0100 || use_way !== 4'b0100) $display("FAIL wm_write_we_use got=%b/%b exp=0100/0100", data_we, use_way); else n_pass++;
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_dirty_wb();
    int g, nw, bad_cw;
    req = 2'b01; req_we = 2'b00;
    g = rr(m_last, req);
    m_last = g;
    nw = 0; bad_cw = 0;
    for (int c = 0; c <= 9; c++) begin
      hit = 4'b0000;
      victim = (c == 1) ? 2'd3 : 2'd0;
      victim_dirty = (c == 2);
      mem_addrok_w = (c == 7);
      mem_addrok_r = (c == 8);
      mem_dataok = (c == 9);
      if (c > 0) req = 2'b00;
      @(negedge clk);
      if (mem_req_w) begin
        nw++;
        if (choose_way !== 2'd3 || tagv_way_sel !== 2'd3) bad_cw++;
      end
      if (c == 8) begin
        n_checks++; if (mem_req_r !== 1'b1 || mem_req_w !== 1'b0) $display("FAIL wb_then_read got=%b%b exp=10", mem_req_r, mem_req_w); else n_pass++;
      end
      if (c == 9) begin
        n_checks++; if (data_ok !== oh2(g)) $display("FAIL wb_data_ok got=%b exp=%b", data_ok, oh2(g)); else n_pass++;
      end
      tick();
    end
    n_checks++; if (nw !== 5) $display("FAIL wb_req_w_cycles got=%0d exp=5", nw); else n_pass++;
    n_checks++; if (bad_cw !== 0) $display("FAIL wb_way_sel bad_cycles=%0d exp=0", bad_cw); else n_pass++;
    quiet();
  endtask

  task automatic test_opflag();
    int g;
    opflag = 1; req = 2'b01;
    @(negedge clk);
    n_checks++; if (addr_ok !== 2'b00 || rbuf_we !== 1'b0) $display("FAIL op_no_accept got=%b/%b exp=00/0", addr_ok, rbuf_we); else n_pass++;
    tick();
    opflag = 0;
    @(negedge clk);
    n_checks++; if (op_done !== 1'b1 || addr_ok !== 2'b00) $display("FAIL op_done got=%b/%b exp=1/00", op_done, addr_ok); else n_pass++;
    tick();
    g = rr(m_last, req);
    m_last = g;
    @(negedge clk);
    n_checks++; if (addr_ok !== oh2(g) || op_done !== 1'b0) $display("FAIL op_then_accept got=%b/%b exp=%b/0", addr_ok, op_done, oh2(g)); else n_pass++;
    tick();
    req = 2'b00; hit = 4'b1000;
    tick();
    quiet();
  endtask

  task automatic test_reset_mid();
    req = 2'b01; req_we = 2'b00;
    m_last = 0;
    tick();
    req = 2'b00;
    tick();
    tick();
    mem_addrok_r = 1;
    tick();
    mem_addrok_r = 0;
    rstn = 0;
    @(negedge clk);
    n_checks++; if (mem_rdy !== 1'b1) $display("FAIL rm_in_wait got=%b exp=1", mem_rdy); else n_pass++;
    tick();
    rstn = 1;
    mem_dataok = 1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || data_ok !== 2'b00) $display("FAIL rm_abandon got=%b/%b exp=0/00", busy, data_ok); else n_pass++;
    tick();
    mem_dataok = 0;
    req = 2'b11;
    m_last = 1;
    @(negedge clk);
    n_checks++; if (addr_ok !== 2'b01) $display("FAIL rm_restart got=%b exp=01", addr_ok); else n_pass++;
    m_last = 0;
    tick();
    req = 2'b00; hit = 4'b0001;
    @(negedge clk);
    n_checks++; if (data_ok !== 2'b01) $display("FAIL rm_data_ok got=%b exp=01", data_ok); else n_pass++;
    tick();
    quiet();
  endtask

  // Random transactions checked against a per-transaction timeline.
  task automatic test_random(input int n);
    logic [1:0] r, wv;
    logic [3:0] hv;
    int g, hidx, v, d, dw, dr, k, we, wb, rq0, rw0, lat, ishit;
    logic [1:0] e_a, e_d;
    logic [3:0] e_use, e_we;
    for (int t = 0; t < n; t++) begin
      r = 2'($urandom_range(1, 3));
      wv = 2'($urandom_range(0, 3));
      hv = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      v = $urandom_range(0, 3);
      d = $urandom_range(0, 1);
      dw = $urandom_range(0, 2);
      dr = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      g = rr(m_last, r);
      m_last = g;
      we = wv[g];
      ishit = (hv != 0);
      hidx = lowest(hv);
      wb = d ? dw + 1 : 0;
      rq0 = 3 + wb;
      rw0 = rq0 + dr + 1;
      lat = ishit ? 1 : rw0 + k - 1 + we;
      for (int c = 0; c <= lat; c++) begin
        req = (c == 0) ? r : 2'($urandom_range(0, 3));
        req_we = (c == 0) ? wv : 2'($urandom_range(0, 3));
        hit = (c == 1) ? hv : 4'($urandom_range(0, 15));
        victim = (c == 1) ? 2'(v) : 2'($urandom_range(0, 3));
        victim_dirty = (c == 2) ? d[0] : 1'($urandom_range(0, 1));
        if (ishit) begin
          mem_addrok_w = 1'($urandom_range(0, 1));
          mem_addrok_r = 1'($urandom_range(0, 1));
          mem_dataok = 1'($urandom_range(0, 1));
        end else begin
          mem_addrok_w = (d && c == 3 + dw) ? 1'b1 :
                         (c >= 3 && c < 3 + wb) ? 1'b0 : 1'($urandom_range(0, 1));
          mem_addrok_r = (c == rq0 + dr) ? 1'b1 :
                         (c >= rq0 && c < rq0 + dr) ? 1'b0 : 1'($urandom_range(0, 1));
          mem_dataok = (c == rw0 + k - 1) ? 1'b1 :
                       (c >= rw0) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        e_a = (c == 0) ? oh2(g) : 2'b00;
        e_d = (c == lat) ? oh2(g) : 2'b00;
        if (ishit) begin
          e_use = (c == 1) ? oh4(hidx) : 4'b0;
          e_we = (c == 1 && we == 1) ? oh4(hidx) : 4'b0;
        end else begin
          e_use = (c == lat) ? oh4(v) : 4'b0;
          e_we = ((c == rw0 + k - 1) || (we == 1 && c == lat)) ? oh4(v) : 4'b0;
        end
        @(negedge clk);
        n_checks++; if (addr_ok !== e_a) $display("FAIL rnd_addr_ok t=%0d c=%0d got=%b exp=%b", t, c, addr_ok, e_a); else n_pass++;
        n_checks++; if (data_ok !== e_d) $display("FAIL rnd_data_ok t=%0d c=%0d got=%b exp=%b", t, c, data_ok, e_d); else n_pass++;
        n_checks++; if (busy !== (c != 0)) $display("FAIL rnd_busy t=%0d c=%0d got=%b", t, c, busy); else n_pass++;
        n_checks++; if (use_way !== e_use) $display("FAIL rnd_use t=%0d c=%0d got=%b exp=%b", t, c, use_way, e_use); else n_pass++;
        n_checks++; if (data_we !== e_we) $display("FAIL rnd_data_we t=%0d c=%0d got=%b exp=%b", t, c, data_we, e_we); else n_pass++;
        n_checks++;
        if (mem_req_w !== (!ishit && c >= 3 && c < 3 + wb) ||
            mem_req_r !== (!ishit && c >= rq0 && c <= rq0 + dr) ||
            mem_rdy !== (!ishit && c >= rw0 && c < rw0 + k))
          $display("FAIL rnd_mem t=%0d c=%0d got w=%b r=%b rdy=%b", t, c, mem_req_w, mem_req_r, mem_rdy);
        else n_pass++;
        tick();
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    rstn = 0;
    #1;
    test_reset();
    test_alternate();
    test_way8();
    test_write_miss();
    test_dirty_wb();
    test_opflag();
    test_random(60);
    test_reset_mid();
    test_random(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2cache_ctrl_fsm.md
# l2cache_ctrl_fsm

Parametrised main control FSM for the write-back, write-allocate L2 cache. It serves `n_src` upstream requesters (I-cache, D-cache, future ports) through a round-robin arbiter and handles an `way`-way set. It sequences lookup, dirty-victim writeback, refill and cache-op execution, and drives the Data/TagV, Dirtytable, PLRU and data-select strobes alongside the existing reqbuf and datapath.

## Interface
Parameters:
- `way`, 4: associativity, power of two, ≥2; `way_w = $clog2(way)`
- `n_src`, 2: upstream requesters, ≥1; `src_w = max(1,$clog2(n_src))`

Ports (`clk`/`rstn`: one clock; reset synchronous, active-low):
- `clk`  in  1  clock
- `rstn`  in  1  synchronous active-low reset
- `req`  in  n_src  per-source request valid
- `req_we`  in  n_src  per-source write (1) / read (0)
- `opflag`  in  1  cache-op pending
- `addr_ok`  out  n_src  one-hot request accept
- `data_ok`  out  n_src  one-hot read data / write ack
- `op_done`  out  1  cache-op complete pulse
- `rbuf_we`  out  1  reqbuf capture strobe
- `cur_src`  out  src_w  source owning the current transaction
- `hit`  in  way  tag-compare hit vector
- `victim`  in  way_w  PLRU victim way
- `victim_dirty`  in  1  dirty bit of victim
- `use`  out  way  one-hot PLRU touch
- `data_we`  out  way  Data write enable
- `data_replace`  out  1  whole-block write
- `tagv_way_sel`, `dirty_way_sel`, `choose_way`  out  way_w  way selects
- `dirty_set1`, `dirty_set0`  out  1  Dirtytable set/clear
- `choose_return`  out  1  select memory return data
- `mem_req_r`, `mem_req_w`, `mem_rdy`  out  1  memory handshake
- `mem_addrok_r`, `mem_addrok_w`, `mem_dataok`  in  1  memory handshake
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOOKUP, OPER, CHK_DIRTY, WB, REFILL_REQ, REFILL_WAIT, REFILL_WRITE.
- IDLE behaviour:
  - `opflag` has priority and goes to OPER; no `addr_ok` that cycle.
  - Otherwise, if any `req` is set, grant one source by round-robin. Assert `addr_ok[g]` and `rbuf_we`, latch `cur_src=g` and `cur_we=req_we[g]`, then go to LOOKUP.
  - Round-robin pointer = last grant. Search starts at last+1 with wrap-around. After reset, last = n_src-1, so source 0 has first priority.
- LOOKUP, hit at way h (lowest set index if several bits are set): pulse `use[h]` and set `choose_way=h`, then go to IDLE.
  - Read hit: `data_ok[cur_src]`.
  - Write hit: `data_we[h]`, `dirty_way_sel=h`, `dirty_set1`, `data_ok[cur_src]`.
- LOOKUP, miss (hit==0): go to CHK_DIRTY, sampling `victim` into a register `vw` for the rest of the transaction.
- CHK_DIRTY: `dirty_way_sel=vw`. `victim_dirty` → WB, else → REFILL_REQ.
- WB: `mem_req_w`, `choose_way=vw`, `tagv_way_sel=vw`, held until `mem_addrok_w`, then → REFILL_REQ.
- REFILL_REQ: `mem_req_r` held until `mem_addrok_r`, then → REFILL_WAIT.
- REFILL_WAIT: `mem_rdy`. On `mem_dataok`:
  - Always: `choose_return`, `data_replace`, `data_we[vw]`, `dirty_way_sel=vw`, `dirty_set0`.
  - Read: also `use[vw]` and `data_ok[cur_src]`, then → IDLE.
  - Write: → REFILL_WRITE.
- REFILL_WRITE: `data_we[vw]`, `use[vw]`, `dirty_way_sel=vw`, `dirty_set1`, `data_ok[cur_src]`, then → IDLE.
- OPER: one cycle; `op_done`, then → IDLE.
- Every output not listed for a state is 0.

## Timing
- Reset (sampled at the `clk` edge while `rstn`=0): state IDLE, pointer = n_src-1, `cur_src`=0, `vw`=0. All outputs are 0 except `addr_ok`/`rbuf_we`, which follow IDLE arbitration.
- Reset mid-transaction abandons it; no `data_ok` is issued.
- Hit latency: `addr_ok` in cycle 0, `data_ok` in cycle 1. A new accept is possible no earlier than cycle 2.
- Clean read miss, with memory accepting immediately and returning data after k cycles of REFILL_WAIT: `data_ok` at cycle 3+k.
  - Dirty victim: +1 minimum (WB).
  - Write miss: +1 (REFILL_WRITE).
- `req` is level; a source that is not granted must hold `req`. Dropping it before grant has no effect.
- `mem_dataok` is sampled only in REFILL_WAIT. `mem_addrok_*` are sampled only in their own state.
- All outputs are combinational from state and registered fields plus the listed inputs. `data_ok`/`addr_ok` are always one-hot or zero.

## Structure
- Shared package `l2cache_pkg`: state enum/localparams, and the `way_w`/`src_w` width functions.
- Sub-module `l2cache_rr_arbiter` (parameter `n_src`): inputs `req`, `en`; outputs one-hot `gnt` and encoded index; pointer updates only when `en` is set and a grant is made.
- One-hot priority encoding of `hit` is inline.

## Test plan
- Reset, then both sources requesting continuously: grants alternate 0,1,0,1, and each `data_ok` arrives exactly one cycle after its `addr_ok`.
- way=8 read hit with `hit`=8'b0010_0000: `use`=8'b0010_0000, `choose_way`=5, `data_ok` goes to the granted source.
- Write miss, `victim`=2 clean, `mem_addrok_r` after 2 cycles, `mem_dataok` after 3:
  - `data_replace` and `dirty_set0` are asserted with `data_we`=4'b0100.
  - REFILL_WRITE follows with `dirty_set1` and `data_ok`.
- Read miss with dirty victim 3 and `mem_addrok_w` delayed 4 cycles: `mem_req_w` held 5 cycles with `choose_way`=3, then `mem_req_r`.
- `opflag` and `req` asserted in the same cycle: OPER first (`op_done`), then `addr_ok` on the following IDLE cycle.
- `rstn` low during REFILL_WAIT: IDLE next cycle, no `data_ok`, arbiter restarts at source 0.
